// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset vector,
// redirect selector encodings and FSM states.
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    SEL_BR  = 2'b00,
    SEL_J   = 2'b01,
    SEL_JR  = 2'b10,
    SEL_RSV = 2'b11
  } sel_e;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } state_e;

endpackage

// File: rtl/ifu_npc.sv
// Next-PC target computation for branch / jump / jr redirects.
// Purely combinational; all state lives in ifu.
module npc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] ext_off,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] link4;

  always_comb begin
    link4    = pc + 32'd4;
    target   = link4 + ext_off;
    misalign = 1'b0;
    case (redirect_sel)
      SEL_BR: target = link4 + ext_off;
      SEL_J:  target = {link4[31:28], j_index, 2'b00};
      SEL_JR: begin
        target   = {jr_target[31:2], 2'b00};
        misalign = (jr_target[1:0] != 2'b00);
      end
      default: target = link4 + ext_off;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one-entry output slot fed from instruction memory,
// with decode-driven stall and control-transfer redirect.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] ext_off,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] link,
  output logic [15:0] imm,
  output logic        instr_valid,
  output logic        addr_err
);

  state_e      state, state_n;
  logic [31:0] fetch_pc;
  logic [31:0] target;
  logic        misalign;
  logic        xfer;
  logic        honoured;

  npc u_npc (
    .pc          (pc),
    .redirect_sel(redirect_sel),
    .ext_off     (ext_off),
    .j_index     (j_index),
    .jr_target   (jr_target),
    .target      (target),
    .misalign    (misalign)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= BOOT;
    else        state <= state_n;
  end

  // Fetch only when the output slot is empty or being drained this cycle.
  always_comb begin
    state_n = state;
    im_req  = 1'b0;
    case (state)
      BOOT:  state_n = FETCH;
      FETCH: im_req  = reset && (!instr_valid || !stall);
      default: state_n = BOOT;
    endcase
  end

  assign xfer     = im_req && im_ready;
  assign honoured = redirect && instr_valid && (redirect_sel != SEL_RSV);
  assign im_addr  = fetch_pc;
  assign link     = pc + 32'd4;
  assign imm      = instr[15:0];

  // Redirect wins over both a completing transfer and stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      instr       <= 32'd0;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      addr_err <= honoured && (redirect_sel == SEL_JR) && misalign;
      if (honoured) begin
        fetch_pc    <= target;
        instr_valid <= 1'b0;
      end else if (xfer) begin
        instr       <= im_rdata;
        pc          <= fetch_pc;
        instr_valid <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus a randomized run
// against a behavioural fetch-stream model.
module tb_ifu;

  logic        clk;
  logic        reset;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        stall;
  logic        redirect;
  logic [1:0]  redirect_sel;
  logic [31:0] ext_off;
  logic [25:0] j_index;
  logic [31:0] jr_target;

  logic        im_req, instr_valid, addr_err;
  logic [31:0] im_addr, instr, pc, link;
  logic [15:0] imm;

  logic        w_im_req, w_instr_valid, w_addr_err;
  logic [31:0] w_im_addr, w_instr, w_pc, w_link;
  logic [15:0] w_imm;

  int nvec = 0;
  int nerr = 0;

  ifu dut (
    .clk(clk), .reset(reset), .im_req(im_req), .im_addr(im_addr),
    .im_ready(im_ready), .im_rdata(im_rdata), .stall(stall),
    .redirect(redirect), .redirect_sel(redirect_sel), .ext_off(ext_off),
    .j_index(j_index), .jr_target(jr_target), .instr(instr), .pc(pc),
    .link(link), .imm(imm), .instr_valid(instr_valid), .addr_err(addr_err)
  );

  ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .im_req(w_im_req), .im_addr(w_im_addr),
    .im_ready(im_ready), .im_rdata(im_rdata), .stall(stall),
    .redirect(redirect), .redirect_sel(redirect_sel), .ext_off(ext_off),
    .j_index(j_index), .jr_target(jr_target), .instr(w_instr), .pc(w_pc),
    .link(w_link), .imm(w_imm), .instr_valid(w_instr_valid), .addr_err(w_addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; im_ready = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_sel = 2'b00; ext_off = 32'd0; j_index = 26'd0; jr_target = 32'd0;
    im_rdata = 32'hDEAD_BEEF;
    step(); step();
    nvec++; if (im_req !== 1'b0) begin nerr++; $display("FAIL rst_req got=%b exp=0", im_req); end
    nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    nvec++; if (pc !== 32'h3000) begin nerr++; $display("FAIL rst_pc got=%h exp=00003000", pc); end
    nvec++; if (im_addr !== 32'h3000) begin nerr++; $display("FAIL rst_addr got=%h exp=00003000", im_addr); end
    nvec++; if (instr !== 32'd0) begin nerr++; $display("FAIL rst_instr got=%h exp=0", instr); end
    nvec++; if (addr_err !== 1'b0) begin nerr++; $display("FAIL rst_err got=%b exp=0", addr_err); end
  endtask

  task automatic test_boot();
    reset = 1'b1; #1;
    nvec++; if (im_req !== 1'b0) begin nerr++; $display("FAIL boot_req got=%b exp=0", im_req); end
    step();
    for (int i = 0; i < 3; i++) begin
      im_rdata = 32'hA000_0000 + i; #1;
      nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3000 + 4 * i) begin
        nerr++; $display("FAIL boot_fetch%0d got=%b/%h exp=1/%h", i, im_req, im_addr, 32'h3000 + 4 * i);
      end
      step();
      nvec++; if (instr_valid !== 1'b1 || pc !== 32'h3000 + 4 * i || instr !== 32'hA000_0000 + i) begin
        nerr++; $display("FAIL boot_out%0d got=%b/%h/%h", i, instr_valid, pc, instr);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; im_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (im_req !== 1'b0) begin nerr++; $display("FAIL stall_req%0d got=%b exp=0", i, im_req); end
      step();
      nvec++; if (instr_valid !== 1'b1 || pc !== 32'h3008 || instr !== 32'hA000_0002) begin
        nerr++; $display("FAIL stall_hold%0d got=%b/%h/%h", i, instr_valid, pc, instr);
      end
    end
    stall = 1'b0; im_rdata = 32'hB000_000C; #1;
    nvec++; if (im_req !== 1'b1 || im_addr !== 32'h300C) begin
      nerr++; $display("FAIL stall_release got=%b/%h exp=1/0000300c", im_req, im_addr);
    end
    step();
    nvec++; if (pc !== 32'h300C || instr !== 32'hB000_000C) begin
      nerr++; $display("FAIL stall_next got=%h/%h", pc, instr);
    end
  endtask

  task automatic test_branch();
    im_rdata = 32'hB000_0010; step();
    redirect = 1'b1; redirect_sel = 2'b00; ext_off = 32'hFFFF_FFF0;
    im_ready = 1'b1; im_rdata = 32'hBAD0_BAD0;
    step();
    redirect = 1'b0;
    nvec++; if (instr_valid !== 1'b0 || im_addr !== 32'h3004) begin
      nerr++; $display("FAIL branch_redir got=%b/%h exp=0/00003004", instr_valid, im_addr);
    end
    im_rdata = 32'hC000_3004; #1;
    nvec++; if (im_req !== 1'b1) begin nerr++; $display("FAIL branch_req got=%b exp=1", im_req); end
    step();
    nvec++; if (instr_valid !== 1'b1 || pc !== 32'h3004 || instr !== 32'hC000_3004) begin
      nerr++; $display("FAIL branch_land got=%b/%h/%h", instr_valid, pc, instr);
    end
  endtask

  task automatic test_jr();
    redirect = 1'b1; redirect_sel = 2'b00; ext_off = 32'h18; step();
    redirect = 1'b0; im_rdata = 32'hD000_3020; step();
    nvec++; if (pc !== 32'h3020 || instr_valid !== 1'b1) begin
      nerr++; $display("FAIL jr_setup got=%h/%b exp=00003020/1", pc, instr_valid);
    end
    redirect = 1'b1; redirect_sel = 2'b10; jr_target = 32'h0000_4006; step();
    redirect = 1'b0; im_ready = 1'b0;
    nvec++; if (im_addr !== 32'h4004 || addr_err !== 1'b1 || instr_valid !== 1'b0) begin
      nerr++; $display("FAIL jr_redir got=%h/%b/%b exp=00004004/1/0", im_addr, addr_err, instr_valid);
    end
    step();
    nvec++; if (addr_err !== 1'b0) begin nerr++; $display("FAIL jr_pulse got=%b exp=0", addr_err); end
    im_ready = 1'b1;
  endtask

  task automatic test_wrap();
    reset = 1'b0; step();
    reset = 1'b1; redirect = 1'b1; redirect_sel = 2'b00; ext_off = 32'h100;
    im_ready = 1'b1; stall = 1'b0; im_rdata = 32'h1234_ABCD;
    step();
    nvec++; if (w_im_req !== 1'b1 || w_im_addr !== 32'hFFFF_FFFC) begin
      nerr++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", w_im_req, w_im_addr);
    end
    step();
    redirect = 1'b0;
    nvec++; if (w_instr_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_im_addr !== 32'h0 || w_instr !== 32'h1234_ABCD) begin
      nerr++; $display("FAIL wrap_first got=%b/%h/%h/%h", w_instr_valid, w_pc, w_im_addr, w_instr);
    end
    im_rdata = 32'h0000_7777; step();
    nvec++; if (w_pc !== 32'h0 || w_link !== 32'h4 || w_imm !== 16'h7777 || w_addr_err !== 1'b0) begin
      nerr++; $display("FAIL wrap_second got=%h/%h/%h/%b", w_pc, w_link, w_imm, w_addr_err);
    end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1; im_ready = 1'b1; step();
    reset = 1'b0; #1;
    nvec++; if (im_req !== 1'b0) begin nerr++; $display("FAIL rmid_req got=%b exp=0", im_req); end
    step();
    nvec++; if (instr_valid !== 1'b0 || im_addr !== 32'h3000 || pc !== 32'h3000) begin
      nerr++; $display("FAIL rmid_state got=%b/%h/%h", instr_valid, im_addr, pc);
    end
    reset = 1'b1; stall = 1'b0;
  endtask

  task automatic test_random();
    logic        m_boot, m_valid, m_err, exp_req, hon;
    logic [31:0] m_fpc, m_instr, m_pc, tgt;
    reset = 1'b0; step();
    m_boot = 1'b1; m_valid = 1'b0; m_err = 1'b0;
    m_fpc = 32'h3000; m_instr = 32'd0; m_pc = 32'h3000;
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 39) != 0);
      im_ready     = ($urandom_range(0, 9) < 7);
      stall        = ($urandom_range(0, 9) < 3);
      redirect     = ($urandom_range(0, 9) < 2);
      redirect_sel = 2'($urandom_range(0, 3));
      ext_off      = {$urandom} & 32'hFFFF_FFFC;
      j_index      = 26'($urandom);
      jr_target    = $urandom;
      im_rdata     = $urandom;
      #1;
      exp_req = reset && !m_boot && (!m_valid || !stall);
      nvec++; if (im_req !== exp_req || im_addr !== m_fpc || instr_valid !== m_valid || addr_err !== m_err) begin
        nerr++; $display("FAIL rnd_ctl c=%0d got=%b/%h/%b/%b exp=%b/%h/%b/%b", c,
                         im_req, im_addr, instr_valid, addr_err, exp_req, m_fpc, m_valid, m_err);
      end
      nvec++; if (pc !== m_pc || instr !== m_instr || link !== m_pc + 32'd4 || imm !== m_instr[15:0]) begin
        nerr++; $display("FAIL rnd_dat c=%0d got=%h/%h/%h exp=%h/%h/%h", c, pc, instr, link, m_pc, m_instr, m_pc + 32'd4);
      end
      if (!reset) begin
        m_boot = 1'b1; m_valid = 1'b0; m_err = 1'b0;
        m_fpc = 32'h3000; m_instr = 32'd0; m_pc = 32'h3000;
      end else begin
        hon = redirect && m_valid && redirect_sel != 2'b11;
        if (redirect_sel == 2'b00)      tgt = m_pc + 32'd4 + ext_off;
        else if (redirect_sel == 2'b01) tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, j_index} * 32'd4);
        else                            tgt = jr_target & 32'hFFFF_FFFC;
        m_err  = hon && redirect_sel == 2'b10 && (jr_target % 4 != 0);
        m_boot = 1'b0;
        if (hon) begin
          m_fpc = tgt; m_valid = 1'b0;
        end else if (exp_req && im_ready) begin
          m_instr = im_rdata; m_pc = m_fpc; m_valid = 1'b1; m_fpc = m_fpc + 32'd4;
        end else if (m_valid && !stall) begin
          m_valid = 1'b0;
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_branch();
    test_jr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
